// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Frames the UART receiver's byte strobes into 6-byte command packets
//   (SYNC, CMD, ADDR, DATA_H, DATA_L, CSUM), checks the XOR checksum and
//   presents validated commands on a valid/ready handshake. Checksum,
//   overflow and (optionally) inter-byte timeout errors are pulsed on o_Err,
//   latched in o_Err_Code and counted in a saturating o_Err_Count.
//
//   Optional feature macro: UART_CMD_TIMEOUT_EN
//     defined   - inter-byte timeout of TIMEOUT_CLKS clocks inside a packet
//     undefined - no timeout counter; a partial packet waits indefinitely
//
// Ports
//   i_Clock, i_Reset          clock, asynchronous active-high reset
//   i_Rx_DV, i_Rx_Byte        byte strobe and byte from the UART receiver
//   o_Cmd_Valid, i_Cmd_Ready  command handshake
//   o_Cmd_Op/Addr/Data        held command fields
//   o_Err, o_Err_Code         error pulse and last cause (01 csum, 10 ovf, 11 tmo)
//   o_Err_Count               saturating error count
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 87000,
  parameter int         ERR_CNT_W    = 8
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  output logic                 o_Cmd_Valid,
  input  logic                 i_Cmd_Ready,
  output logic [7:0]           o_Cmd_Op,
  output logic [7:0]           o_Cmd_Addr,
  output logic [15:0]          o_Cmd_Data,
  output logic                 o_Err,
  output logic [1:0]           o_Err_Code,
  output logic [ERR_CNT_W-1:0] o_Err_Count
);

  if (TIMEOUT_CLKS < 1) begin : g_cfg_check
    $error("uart_cmd_parser: TIMEOUT_CLKS must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA_H, S_DATA_L, S_CSUM, S_EXEC
  } state_t;

  state_t     state;
  logic [7:0] op_sh, addr_sh, dh_sh, dl_sh, csum;
  logic       skid_vld;
  logic [7:0] skid_byte;
  logic       dv, accept, in_pkt, tmo, err_set;
  logic [7:0] rx_byte;
  logic [1:0] err_cd;

  // A byte parked during S_EXEC is replayed as if it had just arrived.
  assign dv      = skid_vld | i_Rx_DV;
  assign rx_byte = skid_vld ? skid_byte : i_Rx_Byte;
  assign accept  = o_Cmd_Valid & i_Cmd_Ready;
  assign in_pkt  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA_H) ||
                   (state == S_DATA_L) || (state == S_CSUM);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TCNT_W-1:0] tcnt;

  // Counts idle clocks since the last byte while a packet is open.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)                 tcnt <= '0;
    else if (!in_pkt || dv || tmo) tcnt <= '0;
    else                         tcnt <= tcnt + 1'b1;
  end

  // An arriving byte beats the timeout in the same cycle.
  assign tmo = in_pkt && !dv && (tcnt == TCNT_W'(TIMEOUT_CLKS));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    err_set = 1'b0;
    err_cd  = 2'b00;
    if (state == S_CSUM && dv && rx_byte != csum) begin
      err_set = 1'b1;
      err_cd  = 2'b01;
    end
    if (state == S_EXEC && o_Cmd_Valid && !accept) begin
      err_set = 1'b1;
      err_cd  = 2'b10;
    end
    if (tmo) begin
      err_set = 1'b1;
      err_cd  = 2'b11;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      op_sh       <= '0;
      addr_sh     <= '0;
      dh_sh       <= '0;
      dl_sh       <= '0;
      csum        <= '0;
      skid_vld    <= 1'b0;
      skid_byte   <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd_Op    <= '0;
      o_Cmd_Addr  <= '0;
      o_Cmd_Data  <= '0;
      o_Err       <= 1'b0;
      o_Err_Code  <= '0;
      o_Err_Count <= '0;
    end else begin
      o_Err <= err_set;
      if (err_set) begin
        o_Err_Code <= err_cd;
        if (o_Err_Count != {ERR_CNT_W{1'b1}}) o_Err_Count <= o_Err_Count + 1'b1;
      end

      if (accept) o_Cmd_Valid <= 1'b0;

      // Skid lives exactly one cycle: loaded in S_EXEC, consumed in S_IDLE.
      skid_vld <= (state == S_EXEC) && i_Rx_DV;
      if ((state == S_EXEC) && i_Rx_DV) skid_byte <= i_Rx_Byte;

      case (state)
        S_IDLE: if (dv && rx_byte == SYNC_BYTE) begin
          state <= S_CMD;
          csum  <= '0;
        end
        S_CMD: if (dv) begin
          op_sh <= rx_byte;
          csum  <= csum ^ rx_byte;
          state <= S_ADDR;
        end
        S_ADDR: if (dv) begin
          addr_sh <= rx_byte;
          csum    <= csum ^ rx_byte;
          state   <= S_DATA_H;
        end
        S_DATA_H: if (dv) begin
          dh_sh <= rx_byte;
          csum  <= csum ^ rx_byte;
          state <= S_DATA_L;
        end
        S_DATA_L: if (dv) begin
          dl_sh <= rx_byte;
          csum  <= csum ^ rx_byte;
          state <= S_CSUM;
        end
        S_CSUM: if (dv) state <= (rx_byte == csum) ? S_EXEC : S_IDLE;
        S_EXEC: begin
          // Reload is allowed when the held command is leaving this cycle.
          if (!o_Cmd_Valid || accept) begin
            o_Cmd_Valid <= 1'b1;
            o_Cmd_Op    <= op_sh;
            o_Cmd_Addr  <= addr_sh;
            o_Cmd_Data  <= {dh_sh, dl_sh};
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (tmo) state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 100;
  localparam int         EW   = 2;   // narrow counter so saturation is reachable

  logic          i_Clock = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Rx_DV = 1'b0;
  logic [7:0]    i_Rx_Byte = '0;
  logic          i_Cmd_Ready = 1'b0;
  logic          o_Cmd_Valid;
  logic [7:0]    o_Cmd_Op, o_Cmd_Addr;
  logic [15:0]   o_Cmd_Data;
  logic          o_Err;
  logic [1:0]    o_Err_Code;
  logic [EW-1:0] o_Err_Count;

  uart_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO), .ERR_CNT_W(EW)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Cmd_Valid(o_Cmd_Valid), .i_Cmd_Ready(i_Cmd_Ready), .o_Cmd_Op(o_Cmd_Op),
    .o_Cmd_Addr(o_Cmd_Addr), .o_Cmd_Data(o_Cmd_Data), .o_Err(o_Err),
    .o_Err_Code(o_Err_Code), .o_Err_Count(o_Err_Count)
  );

  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  // State is "how many bytes of the current packet have been seen" plus the
  // bytes themselves; the command/error outputs follow the rules directly.
  int          n;
  logic [7:0]  pkt [6];
  logic [7:0]  done [6];
  bit          exec_now, def_vld;
  logic [7:0]  def_byte;
  int          idle;
  bit          e_valid, e_err;
  logic [7:0]  e_op, e_addr;
  logic [15:0] e_data;
  logic [1:0]  e_code;
  int          e_cnt;
  logic [15:0] xfers[$];

  task automatic m_reset();
    n = 0; exec_now = 0; def_vld = 0; idle = 0;
    e_valid = 0; e_err = 0; e_op = 0; e_addr = 0; e_data = 0; e_code = 0; e_cnt = 0;
  endtask

  task automatic raise(input logic [1:0] c);
    e_err = 1; e_code = c;
    if (e_cnt < (1 << EW) - 1) e_cnt++;
  endtask

  task automatic m_step();
    bit v0, acc, have;
    logic [7:0] b;
    v0 = e_valid; acc = e_valid && i_Cmd_Ready; have = 0; b = 0;
    e_err = 0;
    if (acc) e_valid = 0;
    if (exec_now) begin
      if (!v0 || acc) begin
        e_valid = 1; e_op = done[1]; e_addr = done[2]; e_data = {done[3], done[4]};
      end else raise(2'b10);
      if (i_Rx_DV) begin def_vld = 1; def_byte = i_Rx_Byte; end
      exec_now = 0;
    end else if (def_vld) begin
      have = 1; b = def_byte; def_vld = 0;
    end else if (i_Rx_DV) begin
      have = 1; b = i_Rx_Byte;
    end
    if (have) begin
      idle = 0;
      if (n == 0) begin
        if (b == SYNC) n = 1;
      end else if (n < 5) begin
        pkt[n] = b; n++;
      end else begin
        n = 0;
        if (b == (pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4])) begin
          done = pkt; exec_now = 1;
        end else raise(2'b01);
      end
    end else if (n > 0) begin
`ifdef UART_CMD_TIMEOUT_EN
      if (idle == TMO) begin raise(2'b11); n = 0; idle = 0; end
      else idle++;
`endif
    end
  endtask

  // Single compare process: outputs are checked mid-cycle, then the model
  // advances using the inputs that the next rising edge will sample.
  initial begin
    m_reset();
    forever begin
      @(negedge i_Clock);
      if (i_Reset) m_reset();
      chk("valid", o_Cmd_Valid, e_valid);
      chk("op",    o_Cmd_Op,    e_op);
      chk("addr",  o_Cmd_Addr,  e_addr);
      chk("data",  o_Cmd_Data,  e_data);
      chk("err",   o_Err,       e_err);
      chk("code",  o_Err_Code,  e_code);
      chk("count", o_Err_Count, e_cnt);
      if (!i_Reset) begin
        if (o_Cmd_Valid && i_Cmd_Ready) xfers.push_back(o_Cmd_Data);
        m_step();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge i_Clock); #1; endtask

  task automatic send(input logic [7:0] b, input int gap);
    i_Rx_DV = 1; i_Rx_Byte = b; tick();
    i_Rx_DV = 0; repeat (gap) tick();
  endtask

  task automatic send6(input logic [47:0] p, input int last_gap);
    logic [47:0] q;
    q = p;
    for (int i = 0; i < 6; i++) send(q[47 - 8*i -: 8], (i == 5) ? last_gap : 2);
  endtask

  task automatic chk_xfers(input string nm, input int sz, input logic [15:0] d0, input logic [15:0] d1);
    chk({nm, "_n"}, xfers.size(), sz);
    if (xfers.size() > 0) chk({nm, "_d0"}, xfers[0], d0);
    if (xfers.size() > 1) chk({nm, "_d1"}, xfers[1], d1);
    xfers.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", o_Cmd_Valid, 0);
    chk("rst_count", o_Err_Count, 0);
    i_Reset = 0; tick();

    // 1: good packet, consumer ready
    i_Cmd_Ready = 1;
    send6(48'hA5_10_22_12_34_14, 4);
    chk("t1_op", o_Cmd_Op, 8'h10);
    chk("t1_addr", o_Cmd_Addr, 8'h22);
    chk("t1_count", o_Err_Count, 0);
    chk_xfers("t1", 1, 16'h1234, 0);

    // 2: bad checksum, then a good packet
    send6(48'hA5_10_22_12_34_15, 4);
    chk("t2_code", o_Err_Code, 2'b01);
    chk("t2_count", o_Err_Count, 1);
    chk("t2_valid", o_Cmd_Valid, 0);
    send6(48'hA5_07_08_BE_EF_5E, 4);
    chk_xfers("t2", 1, 16'hBEEF, 0);

    // 3: overflow while a command is held
    i_Cmd_Ready = 0;
    send6(48'hA5_20_30_00_01_11, 4);
    send6(48'hA5_20_30_00_02_12, 4);
    chk("t3_data", o_Cmd_Data, 16'h0001);
    chk("t3_code", o_Err_Code, 2'b10);
    chk("t3_count", o_Err_Count, 2);
    i_Cmd_Ready = 1;
    repeat (4) tick();
    chk_xfers("t3", 1, 16'h0001, 0);

    // 4: garbage before sync, SYNC value inside payload
    send(8'h00, 2); send(8'hFF, 2); send(8'h5A, 2);
    send6(48'hA5_01_02_A5_A5_03, 4);
    chk("t4_count", o_Err_Count, 2);
    chk_xfers("t4", 1, 16'hA5A5, 0);

    // skid: next SYNC lands in the execute cycle
    send6(48'hA5_10_22_12_34_14, 0);
    send6(48'hA5_07_08_BE_EF_5E, 4);
    chk_xfers("skid", 2, 16'h1234, 16'hBEEF);

    // 5: reset mid-packet with a held command
    i_Cmd_Ready = 0;
    send6(48'hA5_20_30_00_01_11, 4);
    send(8'hA5, 2); send(8'h10, 2); send(8'h22, 0);
    i_Reset = 1;
    repeat (3) tick();
    chk("t5_valid", o_Cmd_Valid, 0);
    chk("t5_data", o_Cmd_Data, 0);
    chk("t5_code", o_Err_Code, 0);
    i_Reset = 0; i_Cmd_Ready = 1; tick();
    send6(48'hA5_07_08_BE_EF_5E, 4);
    chk_xfers("t5", 1, 16'hBEEF, 0);

    // error counter saturates
    for (int k = 0; k < 5; k++) send6(48'hA5_10_22_12_34_15, 3);
    chk("sat_count", o_Err_Count, 3);

    // 6: inter-byte gap inside a packet
    send(8'hA5, 2); send(8'h10, 110);
`ifdef UART_CMD_TIMEOUT_EN
    chk("t6_code", o_Err_Code, 2'b11);
`else
    chk("t6_code", o_Err_Code, 2'b01);
`endif
    chk("t6_count", o_Err_Count, 3);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
